// File: rtl/leaf_out_arbiter.sv
// leaf_out_arbiter: shares the leaf->BFT output link among NUM_OUT_PORTS
// output streams. Round-robin grant gated by per-port credit counters that
// mirror free space in the downstream BRAM buffers. One packet per cycle at
// most, registered onto dout_pkt; nothing is granted while resend is high.
module leaf_out_arbiter #(
   parameter int PACKET_BITS           = 49,
   parameter int NUM_OUT_PORTS         = 2,
   parameter int NUM_PORT_BITS         = 4,
   parameter int NUM_BRAM_ADDR_BITS    = 7,
   parameter int FREESPACE_UPDATE_SIZE = 64
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 resend,
   input  logic [NUM_OUT_PORTS*PACKET_BITS-1:0] req_pkt,
   input  logic [NUM_OUT_PORTS-1:0]             req_vld,
   output logic [NUM_OUT_PORTS-1:0]             req_ack,
   input  logic                                 cred_upd_vld,
   input  logic [NUM_PORT_BITS-1:0]             cred_upd_port,
   output logic [PACKET_BITS-1:0]               dout_pkt,
   output logic [NUM_OUT_PORTS-1:0]             credit_empty
);

   // Credit counters hold 0..CMAX, so they need one bit more than the BRAM
   // address. Arithmetic is done one bit wider again so that credit + update
   // can be compared against CMAX before saturating.
   localparam int            CW       = NUM_BRAM_ADDR_BITS + 1;
   localparam logic [CW:0]   CMAX_EXT = (CW+1)'(2**NUM_BRAM_ADDR_BITS);
   localparam logic [CW:0]   UPD_EXT  = (CW+1)'(FREESPACE_UPDATE_SIZE);
   localparam logic [CW-1:0] CMAX     = CMAX_EXT[CW-1:0];
   localparam logic [NUM_PORT_BITS-1:0] LAST_PORT = NUM_PORT_BITS'(NUM_OUT_PORTS - 1);

   logic [NUM_OUT_PORTS-1:0][CW-1:0] credit_reg;
   logic [NUM_OUT_PORTS-1:0][CW-1:0] credit_next;
   logic [NUM_PORT_BITS-1:0]         rr_ptr_reg;
   logic [NUM_PORT_BITS-1:0]         rr_ptr_next;
   logic [PACKET_BITS-1:0]           dout_reg;
   logic [PACKET_BITS-1:0]           dout_next;
   logic [NUM_OUT_PORTS-1:0]         credit_empty_reg;
   logic [NUM_OUT_PORTS-1:0]         credit_empty_next;
   logic [NUM_OUT_PORTS-1:0]         elig;
   logic                             grant_any;
   logic [NUM_PORT_BITS-1:0]         grant_idx;

   // Per-port eligibility, one-hot ack decode and credit bookkeeping.
   generate
      for (genvar gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_port
         logic          dec;
         logic          inc;
         logic [CW:0]   sum;

         // A port is a candidate only with a packet, credit, and no
         // resend/reset blocking the link.
         assign elig[gi] = req_vld[gi] & (credit_reg[gi] != '0) & ~resend & ~reset;

         assign req_ack[gi] = grant_any & (grant_idx == NUM_PORT_BITS'(gi));

         // Updates addressed beyond the last port match no gi and vanish.
         assign dec = req_ack[gi];
         assign inc = cred_upd_vld & (cred_upd_port == NUM_PORT_BITS'(gi));

         // dec never exceeds credit_reg because a grant needs credit != 0.
         assign sum = {1'b0, credit_reg[gi]}
                    - {{CW{1'b0}}, dec}
                    + (inc ? UPD_EXT : '0);

         assign credit_next[gi]       = (sum > CMAX_EXT) ? CMAX : sum[CW-1:0];
         assign credit_empty_next[gi] = (credit_next[gi] == '0);
      end
   endgenerate

   // Round-robin scan starting at rr_ptr; the first eligible port wins.
   always_comb begin
      int pos;
      grant_any = 1'b0;
      grant_idx = '0;
      pos       = 0;
      for (int k = 0; k < NUM_OUT_PORTS; k++) begin
         pos = int'(rr_ptr_reg) + k;
         if (pos >= NUM_OUT_PORTS) begin
            pos = pos - NUM_OUT_PORTS;
         end
         for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (!grant_any && (pos == i) && elig[i]) begin
               grant_any = 1'b1;
               grant_idx = NUM_PORT_BITS'(i);
            end
         end
      end
   end

   // Select the granted packet and mark it valid; idle cycles send zero.
   always_comb begin
      dout_next = '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
         if (grant_any && (grant_idx == NUM_PORT_BITS'(i))) begin
            dout_next = req_pkt[i*PACKET_BITS +: PACKET_BITS];
         end
      end
      if (grant_any) begin
         dout_next[PACKET_BITS-1] = 1'b1;
      end
   end

   // Pointer moves to the port after the winner, wrapping at the last port.
   always_comb begin
      rr_ptr_next = rr_ptr_reg;
      if (grant_any) begin
         rr_ptr_next = (grant_idx == LAST_PORT) ? '0 : grant_idx + 1'b1;
      end
   end

   // State registers; reset reloads full credit and drops any packet in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            credit_reg[i] <= CMAX;
         end
         rr_ptr_reg       <= '0;
         dout_reg         <= '0;
         credit_empty_reg <= '0;
      end else begin
         credit_reg       <= credit_next;
         rr_ptr_reg       <= rr_ptr_next;
         dout_reg         <= dout_next;
         credit_empty_reg <= credit_empty_next;
      end
   end

   assign dout_pkt     = dout_reg;
   assign credit_empty = credit_empty_reg;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Testbench for leaf_out_arbiter: directed cycle vectors with hand-computed
// acks and credit_empty; expected dout_pkt per cycle goes into a queue that
// an independent monitor drains one cycle later.
module tb_leaf_out_arbiter;

   localparam int PB = 49;
   localparam int NP = 2;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               resend = 1'b0;
   logic [NP*PB-1:0]   req_pkt = '0;
   logic [NP-1:0]      req_vld = '0;
   logic [NP-1:0]      req_ack;
   logic               cred_upd_vld = 1'b0;
   logic [3:0]         cred_upd_port = '0;
   logic [PB-1:0]      dout_pkt;
   logic [NP-1:0]      credit_empty;

   logic [PB-1:0]      exp_q[$];
   logic [PB-1:0]      pkt [NP];
   int                 seq [NP];
   int                 n_cmp = 0;
   int                 n_bad = 0;

   leaf_out_arbiter #(
      .PACKET_BITS(PB),
      .NUM_OUT_PORTS(NP),
      .NUM_PORT_BITS(4),
      .NUM_BRAM_ADDR_BITS(7),
      .FREESPACE_UPDATE_SIZE(64)
   ) dut (
      .clk(clk),
      .reset(reset),
      .resend(resend),
      .req_pkt(req_pkt),
      .req_vld(req_vld),
      .req_ack(req_ack),
      .cred_upd_vld(cred_upd_vld),
      .cred_upd_port(cred_upd_port),
      .dout_pkt(dout_pkt),
      .credit_empty(credit_empty)
   );

   always #5 clk = ~clk;

   function automatic logic [PB-1:0] mk_pkt(input int port, input int s);
      return {1'b0, 4'(port + 1), 44'(s * 37 + 5)};
   endfunction

   // One cycle: drive inputs after the edge, check ack/credit_empty mid-cycle,
   // queue the packet expected on dout_pkt in the following cycle.
   task automatic step(input logic [1:0] vld, input logic rst, input logic rsnd,
                       input logic upd_v, input logic [3:0] upd_p,
                       input logic [1:0] ack_exp, input logic [1:0] ce_exp,
                       input string name);
      logic [PB-1:0] e;
      @(posedge clk);
      #1;
      reset         = rst;
      resend        = rsnd;
      req_vld       = vld;
      cred_upd_vld  = upd_v;
      cred_upd_port = upd_p;
      req_pkt       = {pkt[1], pkt[0]};
      #3;
      n_cmp++;
      if (req_ack !== ack_exp) begin
         n_bad++;
         $display("FAIL %s req_ack: got %b, expected %b (t=%0t)", name, req_ack, ack_exp, $time);
      end
      n_cmp++;
      if (credit_empty !== ce_exp) begin
         n_bad++;
         $display("FAIL %s credit_empty: got %b, expected %b (t=%0t)", name, credit_empty, ce_exp, $time);
      end
      e = '0;
      for (int i = 0; i < NP; i++) begin
         if (ack_exp[i]) begin
            e = pkt[i];
            e[PB-1] = 1'b1;
            seq[i]++;
            pkt[i] = mk_pkt(i, seq[i]);
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic steps(input int n, input logic [1:0] vld, input logic rsnd,
                        input logic [1:0] ack_exp, input logic [1:0] ce_exp,
                        input string name);
      for (int k = 0; k < n; k++) begin
         step(vld, 1'b0, rsnd, 1'b0, 4'd0, ack_exp, ce_exp, name);
      end
   endtask

   // Monitor: each cycle compares dout_pkt with the oldest queued expectation.
   initial begin
      logic [PB-1:0] e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (dout_pkt !== e) begin
               n_bad++;
               $display("FAIL dout_pkt: got %h, expected %h (t=%0t)", dout_pkt, e, $time);
            end else if (e != '0) begin
               $display("pkt out: port %0d data %h (t=%0t)", int'(e[47:44]) - 1, e, $time);
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete, %0d compared", n_cmp);
      $fatal(1, "timeout");
   end

   initial begin
      int w;
      for (int i = 0; i < NP; i++) begin
         seq[i] = 0;
         pkt[i] = mk_pkt(i, 0);
      end

      // Reset: no acks even with requests present.
      step(2'b11, 1, 0, 0, 4'd0, 2'b00, 2'b00, "reset_blocks_ack");
      step(2'b11, 1, 0, 0, 4'd0, 2'b00, 2'b00, "reset");

      // Both ports valid, full credit: strict alternation from port 0.
      step(2'b11, 0, 0, 0, 4'd0, 2'b01, 2'b00, "rr_a0");
      step(2'b11, 0, 0, 0, 4'd0, 2'b10, 2'b00, "rr_a1");
      step(2'b11, 0, 0, 0, 4'd0, 2'b01, 2'b00, "rr_b0");
      step(2'b11, 0, 0, 0, 4'd0, 2'b10, 2'b00, "rr_b1");

      // Port 1 alone for 130 cycles: 128 grants, then credit exhausted.
      step(2'b00, 1, 0, 0, 4'd0, 2'b00, 2'b00, "reset2");
      steps(128, 2'b10, 0, 2'b10, 2'b00, "drain_p1");
      steps(2,   2'b10, 0, 2'b00, 2'b10, "p1_empty");

      // Update to a non-existent port is ignored; a real one adds 64 credits.
      step(2'b10, 0, 0, 1, 4'd3, 2'b00, 2'b10, "upd_oob");
      step(2'b10, 0, 0, 0, 4'd0, 2'b00, 2'b10, "upd_oob_ignored");
      step(2'b10, 0, 0, 1, 4'd1, 2'b00, 2'b10, "upd_p1_at0");
      steps(64,  2'b10, 0, 2'b10, 2'b00, "refill_p1");
      step(2'b10, 0, 0, 0, 4'd0, 2'b00, 2'b10, "refill_p1_empty");

      // Port 0: grant+update at credit 100 saturates to 128.
      steps(28,  2'b01, 0, 2'b01, 2'b10, "p0_to100");
      step(2'b01, 0, 0, 1, 4'd0, 2'b01, 2'b10, "grant_upd_at100");
      steps(128, 2'b01, 0, 2'b01, 2'b10, "p0_after_sat");
      step(2'b01, 0, 0, 0, 4'd0, 2'b00, 2'b11, "p0_empty");

      // Port 0 from zero: update -> 64; drain to 10; grant+update -> 73.
      step(2'b01, 0, 0, 1, 4'd0, 2'b00, 2'b11, "upd_p0_at0");
      steps(54,  2'b01, 0, 2'b01, 2'b10, "p0_to10");
      step(2'b01, 0, 0, 1, 4'd0, 2'b01, 2'b10, "grant_upd_at10");
      steps(73,  2'b01, 0, 2'b01, 2'b10, "p0_after73");
      step(2'b01, 0, 0, 0, 4'd0, 2'b00, 2'b11, "p0_empty2");

      // Refill both, then resend blocks grants and freezes the pointer.
      step(2'b00, 0, 0, 1, 4'd0, 2'b00, 2'b11, "upd_p0");
      step(2'b00, 0, 0, 1, 4'd1, 2'b00, 2'b10, "upd_p1");
      step(2'b11, 0, 0, 0, 4'd0, 2'b10, 2'b00, "rr_from_p1");
      steps(5,   2'b11, 1, 2'b00, 2'b00, "resend");
      step(2'b11, 0, 0, 0, 4'd0, 2'b01, 2'b00, "resume_p0");
      step(2'b11, 0, 0, 0, 4'd0, 2'b10, 2'b00, "resume_p1");
      step(2'b11, 0, 0, 0, 4'd0, 2'b01, 2'b00, "resume_p0b");

      // Reset mid-stream: packet dropped, pointer to 0, full credit again.
      step(2'b11, 1, 0, 0, 4'd0, 2'b00, 2'b00, "reset_mid");
      step(2'b11, 0, 0, 0, 4'd0, 2'b01, 2'b00, "post_reset_first");
      steps(127, 2'b01, 0, 2'b01, 2'b00, "post_reset_p0");
      step(2'b01, 0, 0, 0, 4'd0, 2'b00, 2'b01, "post_reset_p0_empty");
      steps(2,   2'b00, 0, 2'b00, 2'b01, "idle");

      // Let the monitor consume the remaining expectations.
      w = 0;
      while (exp_q.size() > 0 && w < 10) begin
         @(posedge clk);
         #3;
         w++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
